// File: rtl/sudoku_input_conditioner.sv
// Sync, debounce and press-edge detection for the board buttons and write
// switch feeding sudokuMasterTop, with optional hold-to-repeat on directions.
module sudoku_input_conditioner #(
   parameter int DB_CYCLES      = 500000,
   parameter int REPEAT_DELAY   = 25000000,
   parameter int REPEAT_RATE    = 10000000,
   parameter bit BTN_ACTIVE_LOW = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       upRaw,
   input  logic       downRaw,
   input  logic       leftRaw,
   input  logic       rightRaw,
   input  logic       writeRaw,
   output logic       upButton,
   output logic       downButton,
   output logic       leftButton,
   output logic       rightButton,
   output logic       writeSwitch,
   output logic [3:0] heldDir
);

   localparam int CW   = $clog2(DB_CYCLES + 1);
   localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                         REPEAT_DELAY : REPEAT_RATE;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [CW-1:0] DB_M1   = CW'(DB_CYCLES - 1);
   localparam logic [HW-1:0] DLY_M1  =
      HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [HW-1:0] RATE_M1 =
      HW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
   localparam bit REP_EN = (REPEAT_DELAY != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_REPEAT
   } rep_state_t;

   // bit order {up,down,left,right,write}, all normalised to pressed=1
   logic [4:0]    w_raw;
   logic [4:0]    r_sync1;
   logic [4:0]    r_sync2;
   logic [4:0]    r_stable;
   logic [3:0]    r_prev;
   logic [CW-1:0] r_cnt [5];

   rep_state_t    r_state    [4];
   rep_state_t    w_state_nx [4];
   logic [HW-1:0] r_hold;

   logic [3:0]    w_dir;
   logic [3:0]    w_press;
   logic [3:0]    w_rep;
   logic          w_one;
   logic          w_active;

   assign w_raw = {{4{BTN_ACTIVE_LOW}} ^
                   {upRaw, downRaw, leftRaw, rightRaw}, writeRaw};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_prev   <= '0;
         for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_prev  <= r_stable[4:1];
         for (int i = 0; i < 5; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DB_M1) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_dir   = r_stable[4:1];
   assign w_press = w_dir & ~r_prev;
   assign w_one   = (w_dir != 4'd0) &&
                    ((w_dir & (w_dir - 4'd1)) == 4'd0);

   // Repeat only runs while a single direction is held; anything else idles all
   always_comb begin
      w_rep    = '0;
      w_active = 1'b0;
      for (int d = 0; d < 4; d++) begin
         w_state_nx[d] = S_IDLE;
         if (r_state[d] != S_IDLE) w_active = 1'b1;
         if (REP_EN && w_one && w_dir[d]) begin
            case (r_state[d])
               S_IDLE: begin
                  if (w_press[d]) w_state_nx[d] = S_WAIT;
               end
               S_WAIT: begin
                  w_state_nx[d] = S_WAIT;
                  if (r_hold == DLY_M1) begin
                     w_rep[d]      = 1'b1;
                     w_state_nx[d] = S_REPEAT;
                  end
               end
               S_REPEAT: begin
                  w_state_nx[d] = S_REPEAT;
                  if (r_hold == RATE_M1) w_rep[d] = 1'b1;
               end
               default: w_state_nx[d] = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_hold <= '0;
         for (int d = 0; d < 4; d++) r_state[d] <= S_IDLE;
      end else begin
         for (int d = 0; d < 4; d++) r_state[d] <= w_state_nx[d];
         if ((|w_press) || (|w_rep) || !w_active) r_hold <= '0;
         else r_hold <= r_hold + 1'b1;
      end
   end

   assign upButton    = w_press[3] | w_rep[3];
   assign downButton  = w_press[2] | w_rep[2];
   assign leftButton  = w_press[1] | w_rep[1];
   assign rightButton = w_press[0] | w_rep[0];
   assign writeSwitch = r_stable[0];
   assign heldDir     = w_dir;

endmodule

// File: tb/tb_sudoku_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output-change events,
// a negedge monitor pops and compares them as the outputs change.
module tb_sudoku_input_conditioner;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   logic up0 = 1'b1, dn0 = 1'b1, lf0 = 1'b1, rt0 = 1'b1, wr0 = 1'b0;
   logic up1 = 1'b1, dn1 = 1'b1, lf1 = 1'b1, rt1 = 1'b1, wr1 = 1'b0;

   logic       u0, d0, l0, r0, ws0;
   logic [3:0] h0;
   logic       u1, d1, l1, r1, ws1;
   logic [3:0] h1;

   // dut0: no auto-repeat
   sudoku_input_conditioner #(
      .DB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(1),
      .BTN_ACTIVE_LOW(1'b1)
   ) dut0 (
      .CLK(CLK), .RST(RST),
      .upRaw(up0), .downRaw(dn0), .leftRaw(lf0), .rightRaw(rt0),
      .writeRaw(wr0),
      .upButton(u0), .downButton(d0), .leftButton(l0),
      .rightButton(r0), .writeSwitch(ws0), .heldDir(h0)
   );

   // dut1: auto-repeat enabled
   sudoku_input_conditioner #(
      .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8),
      .BTN_ACTIVE_LOW(1'b1)
   ) dut1 (
      .CLK(CLK), .RST(RST),
      .upRaw(up1), .downRaw(dn1), .leftRaw(lf1), .rightRaw(rt1),
      .writeRaw(wr1),
      .upButton(u1), .downButton(d1), .leftButton(l1),
      .rightButton(r1), .writeSwitch(ws1), .heldDir(h1)
   );

   typedef struct packed {
      int          c;
      logic [17:0] v;
   } ev_t;

   ev_t         q[$];
   ev_t         e;
   logic [17:0] snap;
   logic [17:0] prev = '0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          t;
   int          p;
   int          offs [5] = '{20, 28, 36, 44, 52};

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // snapshot layout: {pulses up,down,left,right, writeSwitch, heldDir}
   function automatic logic [8:0] mk(logic [3:0] pl, logic w,
                                     logic [3:0] hd);
      return {pl, w, hd};
   endfunction

   task automatic ev0(int c, logic [8:0] s);
      q.push_back('{c: c, v: {s, 9'd0}});
   endtask

   task automatic ev1(int c, logic [8:0] s);
      q.push_back('{c: c, v: {9'd0, s}});
   endtask

   task automatic step(int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   always @(negedge CLK) begin
      snap = {u0, d0, l0, r0, ws0, h0, u1, d1, l1, r1, ws1, h1};
      if (!RST) begin
         total++;
         if (snap != 18'd0) begin
            bad++;
            $display("FAIL reset_out: cyc=%0d got=%h want=0", cyc, snap);
         end
      end
      if (snap != prev) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change: cyc=%0d got=%h", cyc, snap);
         end else begin
            e = q.pop_front();
            if (e.c != cyc || e.v != snap) begin
               bad++;
               $display("FAIL event: got cyc=%0d v=%h want cyc=%0d v=%h",
                        cyc, snap, e.c, e.v);
            end
         end
      end
      prev = snap;
   end

   initial begin
      step(3);
      RST = 1'b1;
      step(5);

      // single press, long hold, release: one pulse only
      t = cyc;
      up0 = 1'b0;
      ev0(t + 6, mk(4'h8, 1'b0, 4'h8));
      ev0(t + 7, mk(4'h0, 1'b0, 4'h8));
      step(30);
      t = cyc;
      up0 = 1'b1;
      ev0(t + 6, 9'd0);
      step(12);

      // bounces one cycle short of acceptance
      for (int i = 0; i < 10; i++) begin
         lf0 = 1'b0;
         step(3);
         lf0 = 1'b1;
         step(3);
      end
      step(10);

      // simultaneous left+right press
      t = cyc;
      lf0 = 1'b0;
      rt0 = 1'b0;
      ev0(t + 6, mk(4'h3, 1'b0, 4'h3));
      ev0(t + 7, mk(4'h0, 1'b0, 4'h3));
      step(10);
      t = cyc;
      lf0 = 1'b1;
      rt0 = 1'b1;
      ev0(t + 6, 9'd0);
      step(12);

      // write switch and up on the same edge
      t = cyc;
      wr0 = 1'b1;
      up0 = 1'b0;
      ev0(t + 6, mk(4'h8, 1'b1, 4'h8));
      ev0(t + 7, mk(4'h0, 1'b1, 4'h8));
      step(20);
      t = cyc;
      wr0 = 1'b0;
      up0 = 1'b1;
      ev0(t + 6, 9'd0);
      step(12);

      // right held: repeats at +20 then every 8
      t = cyc;
      p = t + 6;
      rt1 = 1'b0;
      ev1(p, mk(4'h1, 1'b0, 4'h1));
      ev1(p + 1, mk(4'h0, 1'b0, 4'h1));
      foreach (offs[i]) begin
         ev1(p + offs[i], mk(4'h1, 1'b0, 4'h1));
         ev1(p + offs[i] + 1, mk(4'h0, 1'b0, 4'h1));
      end
      ev1(p + 60, 9'd0);
      step(60);
      rt1 = 1'b1;
      step(12);

      // up repeating, down accepted on the cycle up would repeat
      t = cyc;
      p = t + 6;
      up1 = 1'b0;
      ev1(p, mk(4'h8, 1'b0, 4'h8));
      ev1(p + 1, mk(4'h0, 1'b0, 4'h8));
      ev1(p + 20, mk(4'h8, 1'b0, 4'h8));
      ev1(p + 21, mk(4'h0, 1'b0, 4'h8));
      ev1(p + 28, mk(4'h8, 1'b0, 4'h8));
      ev1(p + 29, mk(4'h0, 1'b0, 4'h8));
      ev1(p + 36, mk(4'h4, 1'b0, 4'hC));
      ev1(p + 37, mk(4'h0, 1'b0, 4'hC));
      step(36);
      dn1 = 1'b0;
      step(44);
      up1 = 1'b1;
      dn1 = 1'b1;
      ev1(t + 86, 9'd0);
      step(12);

      // reset while right is held
      t = cyc;
      rt1 = 1'b0;
      ev1(t + 6, mk(4'h1, 1'b0, 4'h1));
      ev1(t + 7, mk(4'h0, 1'b0, 4'h1));
      ev1(t + 12, 9'd0);
      ev1(t + 21, mk(4'h1, 1'b0, 4'h1));
      ev1(t + 22, mk(4'h0, 1'b0, 4'h1));
      step(12);
      RST = 1'b0;
      step(3);
      RST = 1'b1;
      step(15);
      rt1 = 1'b1;
      ev1(t + 36, 9'd0);
      step(12);

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_events: got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sudoku_input_conditioner.md
Name: sudoku_input_conditioner

Overview:
Front-end conditioning stage that sits directly upstream of sudokuMasterTop. It takes the raw board pushbuttons and the write switch and drives the game's upButton/downButton/leftButton/rightButton and writeSwitch inputs. It synchronizes, debounces, and edge-detects each input, and adds optional hold-to-repeat on the direction buttons. The game core therefore sees exactly one clean single-cycle pulse per cursor move.

Parameters:
DB_CYCLES, 500000, consecutive stable samples required to accept a level change (10 ms at 50 MHz).
REPEAT_DELAY, 25000000, cycles a lone direction must stay held before the first auto-repeat pulse; 0 disables auto-repeat.
REPEAT_RATE, 10000000, cycles between subsequent auto-repeat pulses; must be at least 1.
BTN_ACTIVE_LOW, 1, 1 means raw buttons read 0 when pressed; 0 means they read 1 when pressed. Does not apply to the switch.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
upRaw  in  1  raw up pushbutton
downRaw  in  1  raw down pushbutton
leftRaw  in  1  raw left pushbutton
rightRaw  in  1  raw right pushbutton
writeRaw  in  1  raw write slide switch, active-high
upButton  out  1  single-cycle move-up pulse
downButton  out  1  single-cycle move-down pulse
leftButton  out  1  single-cycle move-left pulse
rightButton  out  1  single-cycle move-right pulse
writeSwitch  out  1  debounced write-enable level
heldDir  out  4  debounced pressed levels, bit order {up,down,left,right}

Behaviour:
- One clock, CLK. RST is asynchronous and active-low. While RST=0, all flops clear: sync stages, counters, stable levels, repeat state.
- Reset values: every output is 0.
- Polarity: button inputs are normalised to "pressed=1" before the synchronizer, according to BTN_ACTIVE_LOW.
- Synchronizer: each of the 5 inputs passes through a 2-flop synchronizer (sync1, sync2).
- Debounce, per input:
  - Counter cnt, width $clog2(DB_CYCLES+1).
  - If sync2==stable, cnt<=0.
  - Otherwise cnt<=cnt+1. When cnt==DB_CYCLES-1, stable<=sync2 and cnt<=0.
  - A mismatch shorter than DB_CYCLES consecutive cycles never changes stable.
- Latency: a clean level change sampled by sync1 at edge k changes stable at edge k+DB_CYCLES+1. Pulse and level outputs update on that same edge.
- Press pulse: on the edge where a direction's stable goes 0->1, its output pulse is 1 for exactly one cycle. No pulse is produced on release.
- Auto-repeat (REPEAT_DELAY!=0), per-direction FSM:
  - States IDLE, WAIT, REPEAT; one shared hold counter.
  - IDLE->WAIT on a press pulse; hold counter cleared.
  - WAIT->REPEAT when the hold counter reaches REPEAT_DELAY-1: emit one pulse, clear the counter.
  - In REPEAT, emit one pulse each time the counter reaches REPEAT_RATE-1, then clear it.
  - Any state->IDLE when that direction's stable goes 0.
  - Repeat runs only while exactly one direction is stable-pressed. When a second direction becomes pressed, all directions return to IDLE with no repeat pulses. The newly pressed direction still emits its own press pulse.
- Simultaneous presses: press pulses are independent, so two directions accepted on the same edge both pulse in that cycle.
- writeSwitch: equals the debounced stable level of writeRaw. No pulse, no repeat.
- heldDir: equals the debounced stable levels of the four directions.
- Reset mid-operation: outputs drop to 0 immediately. A button held across reset release is treated as a new press: one pulse after the debounce latency. A switch held high across reset release gives writeSwitch=1 after the same latency.
- Counters never wrap: they always clear on match, accept, or pulse.

Test Plan:
1. DB_CYCLES=4, REPEAT_DELAY=0, BTN_ACTIVE_LOW=1. Drive upRaw 1->0 just before edge k and hold it. Required: upButton=1 only in the cycle after edge k+5, heldDir=4'b1000 from that edge, no further pulses; release gives heldDir=0 and no pulse.
2. Same parameters. Hold leftRaw low for 3 cycles, then high, repeating 10 times. Required: leftButton and heldDir stay 0 throughout.
3. DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8. Hold rightRaw for 60 cycles after its press pulse. Required: rightButton pulses at +0, +20, +28, +36, +44, +52.
4. Same parameters, up held in REPEAT. Press down. Required: one downButton pulse, no further up or down repeat pulses while both are held.
5. DB_CYCLES=4, rightRaw held. Assert RST=0 for 3 cycles, then release. Required: all outputs 0 during reset; exactly one rightButton pulse 6 edges after release.
6. DB_CYCLES=4. Drive writeRaw=1 and upRaw pressed on the same edge. Required: writeSwitch=1 and the upButton pulse appear on the same edge.
